// File: rtl/rv32_mod_mem_arbiter_if.sv
// rv32_mod_mem_arbiter_if: the core's single req/ack external memory bus.
// master modport = arbiter side, slave modport = memory side.
interface rv32_mod_mem_arbiter_if;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_data_o;
    logic        data_ack;
    logic        data_err;
    logic [31:0] data_data_i;

    modport master (
        output data_req, data_wr, data_be, data_addr, data_data_o,
        input  data_ack, data_err, data_data_i
    );

    modport slave (
        input  data_req, data_wr, data_be, data_addr, data_data_o,
        output data_ack, data_err, data_data_i
    );
endinterface

// File: rtl/rv32_mod_mem_arbiter.sv
// rv32_mod_mem_arbiter: shares one memory bus between instruction fetch and
// the LSU. One grant at a time, held until ack/err/abort, alternating on ties.
// Optional feature macro: RV32_MEM_ARB_BUS_TIMEOUT_EN (forced error after
// TIMEOUT_CYCLES grant cycles without a bus response).
module rv32_mod_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_req,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_data_o,
    output logic        instr_ack,
    output logic        instr_err,
    input  logic        lsu_req,
    input  logic        lsu_wr,
    input  logic [3:0]  lsu_be,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_data_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_ack,
    output logic        lsu_err,
    rv32_mod_mem_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2
    } state_t;

    // last_gnt encoding: 0 = fetch side, 1 = LSU side
    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    state_t state_r;
    state_t state_nxt;
    logic   last_gnt_r;
    logic   last_gnt_nxt;
    logic   gnt_i_s;
    logic   gnt_d_s;
    logic   bus_done_s;
    logic   tout_hit_s;
    logic   tout_err_i_r;
    logic   tout_err_d_r;

    assign gnt_i_s    = (state_r == ST_GNT_I);
    assign gnt_d_s    = (state_r == ST_GNT_D);
    assign bus_done_s = bus.data_ack | bus.data_err;

`ifdef RV32_MEM_ARB_BUS_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? 16 : 8;

    logic [CNT_W-1:0] cnt_r;

    // Grant-cycle counter: cleared while idle, advances every granted cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (state_r == ST_IDLE) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign tout_hit_s = (state_r != ST_IDLE) &&
                        (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

    // Forced-error pulse, registered so it appears in the cycle after the
    // last grant cycle, when the bus request has already dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            tout_err_i_r <= 1'b0;
            tout_err_d_r <= 1'b0;
        end else begin
            tout_err_i_r <= gnt_i_s & instr_req & ~bus_done_s & tout_hit_s;
            tout_err_d_r <= gnt_d_s & lsu_req   & ~bus_done_s & tout_hit_s;
        end
    end
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = TIMEOUT_CYCLES;
    assign tout_hit_s     = 1'b0;
    assign tout_err_i_r   = 1'b0;
    assign tout_err_d_r   = 1'b0;
`endif

    // State and last-grant registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            last_gnt_r <= SIDE_I;
        end else begin
            state_r    <= state_nxt;
            last_gnt_r <= last_gnt_nxt;
        end
    end

    // Next-state: alternate on ties, hold a grant until response or abort.
    always_comb begin
        state_nxt    = state_r;
        last_gnt_nxt = last_gnt_r;
        case (state_r)
            ST_IDLE: begin
                if (tout_err_i_r || tout_err_d_r) begin
                    // error cycle doubles as the response cycle; no new grant
                    state_nxt = ST_IDLE;
                end else if (instr_req && lsu_req) begin
                    if (last_gnt_r == SIDE_I) begin
                        state_nxt    = ST_GNT_D;
                        last_gnt_nxt = SIDE_D;
                    end else begin
                        state_nxt    = ST_GNT_I;
                        last_gnt_nxt = SIDE_I;
                    end
                end else if (lsu_req) begin
                    state_nxt    = ST_GNT_D;
                    last_gnt_nxt = SIDE_D;
                end else if (instr_req) begin
                    state_nxt    = ST_GNT_I;
                    last_gnt_nxt = SIDE_I;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_GNT_I: begin
                if (bus_done_s || !instr_req || tout_hit_s) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_GNT_I;
                end
            end
            ST_GNT_D: begin
                if (bus_done_s || !lsu_req || tout_hit_s) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_GNT_D;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Bus drive follows the registered grant; nothing is driven while idle.
    assign bus.data_req    = gnt_i_s | gnt_d_s;
    assign bus.data_wr     = gnt_d_s & lsu_wr;
    assign bus.data_be     = gnt_d_s ? lsu_be   : (gnt_i_s ? 4'b1111 : 4'b0000);
    assign bus.data_addr   = gnt_d_s ? lsu_addr : (gnt_i_s ? instr_addr : 32'h0000_0000);
    assign bus.data_data_o = gnt_d_s ? lsu_data_i : 32'h0000_0000;

    // Responses steered only to the granted side; err beats ack.
    assign instr_ack    = bus.data_ack & ~bus.data_err & gnt_i_s;
    assign instr_err    = (bus.data_err & gnt_i_s) | tout_err_i_r;
    assign instr_data_o = gnt_i_s ? bus.data_data_i : 32'h0000_0000;
    assign lsu_ack      = bus.data_ack & ~bus.data_err & gnt_d_s;
    assign lsu_err      = (bus.data_err & gnt_d_s) | tout_err_d_r;
    assign lsu_data_o   = gnt_d_s ? bus.data_data_i : 32'h0000_0000;

endmodule

// File: tb/tb_rv32_mod_mem_arbiter.sv
// Directed bench for rv32_mod_mem_arbiter. Honours RV32_MEM_ARB_BUS_TIMEOUT_EN.
module tb_rv32_mod_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic [31:0] instr_data_o;
    logic        instr_ack;
    logic        instr_err;
    logic        lsu_req;
    logic        lsu_wr;
    logic [3:0]  lsu_be;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_data_i;
    logic [31:0] lsu_data_o;
    logic        lsu_ack;
    logic        lsu_err;

    int n_cmp = 0;
    int n_err = 0;

    rv32_mod_mem_arbiter_if bus ();

    rv32_mod_mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr_req    (instr_req),
        .instr_addr   (instr_addr),
        .instr_data_o (instr_data_o),
        .instr_ack    (instr_ack),
        .instr_err    (instr_err),
        .lsu_req      (lsu_req),
        .lsu_wr       (lsu_wr),
        .lsu_be       (lsu_be),
        .lsu_addr     (lsu_addr),
        .lsu_data_i   (lsu_data_i),
        .lsu_data_o   (lsu_data_o),
        .lsu_ack      (lsu_ack),
        .lsu_err      (lsu_err),
        .bus          (bus.master)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        instr_req = 1'b0; instr_addr = 32'h0;
        lsu_req = 1'b0; lsu_wr = 1'b0; lsu_be = 4'h0; lsu_addr = 32'h0; lsu_data_i = 32'h0;
        bus.data_ack = 1'b0; bus.data_err = 1'b0; bus.data_data_i = 32'h0;

        // reset state
        step(); step();
        chk("rst_req",  {31'd0, bus.data_req}, 32'd0);
        chk("rst_be",   {28'd0, bus.data_be}, 32'd0);
        chk("rst_addr", bus.data_addr, 32'd0);
        chk("rst_ack",  {30'd0, instr_ack, lsu_ack}, 32'd0);

        // single fetch: request in cycle 0, grant in cycle 1, ack in cycle 3
        step();
        reset = 1'b0; instr_req = 1'b1; instr_addr = 32'h0000_0100;
        #1 chk("f_idle_req", {31'd0, bus.data_req}, 32'd0);
        step(); #1;
        chk("f_req",   {31'd0, bus.data_req}, 32'd1);
        chk("f_wr",    {31'd0, bus.data_wr}, 32'd0);
        chk("f_be",    {28'd0, bus.data_be}, 32'hF);
        chk("f_addr",  bus.data_addr, 32'h0000_0100);
        chk("f_wdata", bus.data_data_o, 32'd0);
        step();
        step();
        bus.data_ack = 1'b1; bus.data_data_i = 32'hDEAD_BEEF;
        #1;
        chk("f_ack",   {31'd0, instr_ack}, 32'd1);
        chk("f_rdata", instr_data_o, 32'hDEAD_BEEF);
        chk("f_lsu_q", {31'd0, lsu_ack}, 32'd0);
        chk("f_lsu_d", lsu_data_o, 32'd0);
        step();
        bus.data_ack = 1'b0; instr_req = 1'b0;
        #1 chk("f_turn", {31'd0, bus.data_req}, 32'd0);

        // tie out of reset: D, I, D, I
        reset = 1'b1;
        step();
        reset = 1'b0;
        instr_req = 1'b1; instr_addr = 32'h0000_0100;
        lsu_req = 1'b1; lsu_wr = 1'b0; lsu_be = 4'hF; lsu_addr = 32'h0000_0300;
        for (int k = 0; k < 4; k++) begin
            step(); #1;
            chk("tie_req", {31'd0, bus.data_req}, 32'd1);
            chk("tie_addr", bus.data_addr, (k % 2 == 0) ? 32'h0000_0300 : 32'h0000_0100);
            bus.data_ack = 1'b1; bus.data_data_i = 32'h1111_0000 + k;
            #1;
            chk("tie_iack", {31'd0, instr_ack}, (k % 2 == 0) ? 32'd0 : 32'd1);
            chk("tie_dack", {31'd0, lsu_ack},   (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("tie_dq",   lsu_data_o, (k % 2 == 0) ? 32'h1111_0000 + k : 32'd0);
            step();
            bus.data_ack = 1'b0;
            #1 chk("tie_turn", {31'd0, bus.data_req}, 32'd0);
        end

        // store passthrough then ack+err together (err wins)
        instr_req = 1'b0;
        lsu_req = 1'b1; lsu_wr = 1'b1; lsu_be = 4'b0100;
        lsu_addr = 32'h0000_2000; lsu_data_i = 32'h00AA_0000;
        step(); #1;
        chk("st_req",   {31'd0, bus.data_req}, 32'd1);
        chk("st_wr",    {31'd0, bus.data_wr}, 32'd1);
        chk("st_be",    {28'd0, bus.data_be}, 32'h4);
        chk("st_addr",  bus.data_addr, 32'h0000_2000);
        chk("st_wdata", bus.data_data_o, 32'h00AA_0000);
        step();
        bus.data_ack = 1'b1; bus.data_err = 1'b1;
        #1;
        chk("e_lerr", {31'd0, lsu_err}, 32'd1);
        chk("e_lack", {31'd0, lsu_ack}, 32'd0);
        chk("e_i",    {30'd0, instr_ack, instr_err}, 32'd0);
        step();
        bus.data_ack = 1'b0; bus.data_err = 1'b0; lsu_req = 1'b0; lsu_wr = 1'b0;
        #1 chk("e_turn", {31'd0, bus.data_req}, 32'd0);

        // reset during GNT_I with a pending ack
        instr_req = 1'b1;
        step(); #1;
        chk("r_gnt", {31'd0, bus.data_req}, 32'd1);
        reset = 1'b1;
        step();
        bus.data_ack = 1'b1;
        #1;
        chk("r_req", {31'd0, bus.data_req}, 32'd0);
        chk("r_ack", {31'd0, instr_ack}, 32'd0);
        reset = 1'b0; instr_req = 1'b0; bus.data_ack = 1'b0;
        step();

        // abort: lsu_req drops during GNT_D, later ack not forwarded
        lsu_req = 1'b1; lsu_addr = 32'h0000_0040;
        step(); #1;
        chk("a_gnt", {31'd0, bus.data_req}, 32'd1);
        lsu_req = 1'b0;
        step();
        bus.data_ack = 1'b1; bus.data_data_i = 32'hCAFE_F00D;
        #1;
        chk("a_req",  {31'd0, bus.data_req}, 32'd0);
        chk("a_ack",  {31'd0, lsu_ack}, 32'd0);
        chk("a_data", lsu_data_o, 32'd0);
        step();
        bus.data_ack = 1'b0;

`ifdef RV32_MEM_ARB_BUS_TIMEOUT_EN
        // timeout after 4 grant cycles: one-cycle registered lsu_err
        lsu_req = 1'b1;
        step(); step(); step(); step(); #1;
        chk("t_g4_req", {31'd0, bus.data_req}, 32'd1);
        chk("t_g4_err", {31'd0, lsu_err}, 32'd0);
        step();
        bus.data_ack = 1'b1;
        #1;
        chk("t_err",  {31'd0, lsu_err}, 32'd1);
        chk("t_req",  {31'd0, bus.data_req}, 32'd0);
        chk("t_ack",  {31'd0, lsu_ack}, 32'd0);
        step();
        bus.data_ack = 1'b0; lsu_req = 1'b0;
        #1;
        chk("t_pulse", {31'd0, lsu_err}, 32'd0);
        chk("t_idle",  {31'd0, bus.data_req}, 32'd0);
`else
        // no timeout: grant still held after 100 cycles
        lsu_req = 1'b1;
        for (int c = 0; c < 100; c++) begin
            step();
        end
        #1;
        chk("nt_req", {31'd0, bus.data_req}, 32'd1);
        chk("nt_err", {31'd0, lsu_err}, 32'd0);
        lsu_req = 1'b0;
        step(); #1;
        chk("nt_idle", {31'd0, bus.data_req}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
